// File: rtl/edge_event_arb.sv
// Edge-event collector: per-channel edge detect with a 1-deep pending flag,
// round-robin serialisation onto a single valid/ready event port, sticky overflow.
module edge_event_arb #(
  parameter int unsigned N = 8,
  parameter string EDGE = "POS",
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [N-1:0]     en,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_ch,
  output logic             ev_rise,
  output logic [N-1:0]     ovf,
  input  logic             ovf_clr
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("edge_event_arb: N must be in 2..32");
  end
  if (EDGE != "POS" && EDGE != "NEG" && EDGE != "BOTH") begin : g_bad_edge
    $error("edge_event_arb: EDGE must be POS, NEG or BOTH");
  end

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e            state_q, state_d;
  logic [N-1:0]     in_d_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     pend_rise_q, pend_rise_d;
  logic [N-1:0]     ovf_q, ovf_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] ev_ch_q, ev_ch_d;
  logic             ev_rise_q, ev_rise_d;

  logic [N-1:0]     det;
  logic [N-1:0]     new_edge;
  logic [N-1:0]     gnt_onehot;
  logic [N-1:0]     pend_left;
  logic [N-1:0]     fresh;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] grant;
  logic             found;
  logic             loadable;
  logic             do_grant;

  if (EDGE == "POS") begin : g_pos
    assign det = in & ~in_d_q;
  end else if (EDGE == "NEG") begin : g_neg
    assign det = ~in & in_d_q;
  end else begin : g_both
    assign det = in ^ in_d_q;
  end

  // First pending channel at or after rr_ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(rr_ptr_q) + k) % N);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    loadable   = (state_q == StEmpty) || ev_ready;
    do_grant   = loadable && found;
    state_d    = state_q;
    ev_ch_d    = ev_ch_q;
    ev_rise_d  = ev_rise_q;
    rr_ptr_d   = rr_ptr_q;
    if (loadable) begin
      if (found) begin
        state_d   = StFull;
        ev_ch_d   = grant;
        ev_rise_d = pend_rise_q[grant];
        rr_ptr_d  = (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);
      end else begin
        state_d = StEmpty;
      end
    end

    // A channel granted this cycle is free again, so a coincident edge re-arms it.
    gnt_onehot  = do_grant ? (N'(1) << grant) : '0;
    pend_left   = pending_q & ~gnt_onehot;
    new_edge    = det & en;
    fresh       = new_edge & ~pend_left;
    pending_d   = pend_left | new_edge;
    pend_rise_d = (pend_rise_q & ~fresh) | (in & fresh);
    ovf_d       = (ovf_clr ? '0 : ovf_q) | (new_edge & pend_left);
  end

  always_ff @(posedge clk) begin
    in_d_q <= in;
    if (rst) begin
      state_q     <= StEmpty;
      pending_q   <= '0;
      pend_rise_q <= '0;
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
      ev_ch_q     <= '0;
      ev_rise_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_rise_q <= pend_rise_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      ev_ch_q     <= ev_ch_d;
      ev_rise_q   <= ev_rise_d;
    end
  end

  assign ev_valid = (state_q == StFull);
  assign ev_ch    = ev_ch_q;
  assign ev_rise  = ev_rise_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_edge_event_arb.sv
// Bench for edge_event_arb: POS, NEG and BOTH instances (N=4) share stimulus and are
// compared every cycle against a queue-free behavioural model of the event scheduler.
module tb_edge_event_arb;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] in_v;
  logic [N-1:0] en_v;
  logic         rdy;
  logic         clr;

  logic [2:0]   dv;
  logic [2:0]   dr;
  logic [1:0]   dch [3];
  logic [N-1:0] dov [3];

  edge_event_arb #(.N(N), .EDGE("POS")) u_pos (
    .clk(clk), .rst(rst), .in(in_v), .en(en_v), .ev_valid(dv[0]), .ev_ready(rdy),
    .ev_ch(dch[0]), .ev_rise(dr[0]), .ovf(dov[0]), .ovf_clr(clr)
  );
  edge_event_arb #(.N(N), .EDGE("NEG")) u_neg (
    .clk(clk), .rst(rst), .in(in_v), .en(en_v), .ev_valid(dv[1]), .ev_ready(rdy),
    .ev_ch(dch[1]), .ev_rise(dr[1]), .ovf(dov[1]), .ovf_clr(clr)
  );
  edge_event_arb #(.N(N), .EDGE("BOTH")) u_both (
    .clk(clk), .rst(rst), .in(in_v), .en(en_v), .ev_valid(dv[2]), .ev_ready(rdy),
    .ev_ch(dch[2]), .ev_rise(dr[2]), .ovf(dov[2]), .ovf_clr(clr)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model, one copy per edge mode (0=POS, 1=NEG, 2=BOTH).
  bit          m_valid [3];
  int unsigned m_ch    [3];
  bit          m_rise  [3];
  bit          m_ovf   [3][N];
  bit          m_pend  [3][N];
  bit          m_prise [3][N];
  int unsigned m_rr    [3];
  bit          m_prev  [3][N];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_edge(int c, bit now, bit was);
    case (c)
      0:       return now && !was;
      1:       return !now && was;
      default: return now != was;
    endcase
  endfunction

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        m_valid[c] = 0; m_ch[c] = 0; m_rise[c] = 0; m_rr[c] = 0;
        for (int i = 0; i < N; i++) begin
          m_ovf[c][i] = 0; m_pend[c][i] = 0; m_prise[c][i] = 0; m_prev[c][i] = in_v[i];
        end
      end else begin
        if (!m_valid[c] || rdy) begin
          int g = -1;
          for (int k = 0; k < N; k++) begin
            int unsigned ch = (m_rr[c] + k) % N;
            if (g < 0 && m_pend[c][ch]) g = int'(ch);
          end
          if (g >= 0) begin
            m_valid[c] = 1;
            m_ch[c] = g;
            m_rise[c] = m_prise[c][g];
            m_pend[c][g] = 0;
            m_rr[c] = (g + 1) % N;
          end else begin
            m_valid[c] = 0;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (clr) m_ovf[c][i] = 0;
          if (en_v[i] && is_edge(c, in_v[i], m_prev[c][i])) begin
            if (m_pend[c][i]) m_ovf[c][i] = 1;
            else begin
              m_pend[c][i] = 1;
              m_prise[c][i] = in_v[i];
            end
          end
          m_prev[c][i] = in_v[i];
        end
      end
    end
  endtask

  task automatic compare();
    for (int c = 0; c < 3; c++) begin
      logic [N-1:0] exp_ovf;
      for (int i = 0; i < N; i++) exp_ovf[i] = m_ovf[c][i];
      check($sformatf("m%0d_valid", c), dv[c], m_valid[c]);
      if (m_valid[c]) begin
        check($sformatf("m%0d_ch", c), dch[c], m_ch[c]);
        check($sformatf("m%0d_rise", c), dr[c], m_rise[c]);
      end
      check($sformatf("m%0d_ovf", c), dov[c], exp_ovf);
    end
  endtask

  // Apply inputs for one clock, advance the model, then compare at the falling edge.
  task automatic cycle(input logic [N-1:0] i, input logic [N-1:0] e, input logic r,
                       input logic cl, input logic rs);
    in_v = i; en_v = e; rdy = r; clr = cl; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [N-1:0] cur;
    in_v = '0; en_v = '1; rdy = 1'b1; clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    repeat (3) cycle(4'b0000, 4'b1111, 1, 0, 1);
    check("rst_valid", dv[0], 0);
    check("rst_ch", dch[0], 0);
    check("rst_rise", dr[0], 0);
    check("rst_ovf", dov[0], 0);
    cycle(4'b0000, 4'b1111, 1, 0, 0);

    // Single rise on ch2: two-cycle latency, one-cycle event, fall ignored by POS.
    cycle(4'b0100, 4'b1111, 1, 0, 0);
    check("lat_t1", dv[0], 0);
    cycle(4'b0100, 4'b1111, 1, 0, 0);
    check("lat_t2_valid", dv[0], 1);
    check("lat_t2_ch", dch[0], 2);
    check("lat_t2_rise", dr[0], 1);
    cycle(4'b0100, 4'b1111, 1, 0, 0);
    check("one_shot", dv[0], 0);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    check("pos_fall_quiet", dv[0], 0);
    check("neg_fall_ev", dv[1], 1);
    check("neg_fall_rise", dr[1], 0);
    repeat (2) cycle(4'b0000, 4'b1111, 1, 0, 0);

    // One-cycle pulse on ch1: BOTH emits rise then fall.
    cycle(4'b0010, 4'b1111, 1, 0, 0);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    check("both_rise", dr[2], 1);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    check("both_fall_ch", dch[2], 1);
    check("both_fall", dr[2], 0);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    check("both_no_ovf", dov[2], 0);

    // Round-robin order from a fresh pointer.
    cycle(4'b0000, 4'b1111, 1, 0, 1);
    cycle(4'b1011, 4'b1111, 1, 0, 0);
    cycle(4'b1011, 4'b1111, 1, 0, 0);
    check("rr_a0", dch[0], 0);
    cycle(4'b1011, 4'b1111, 1, 0, 0);
    check("rr_a1", dch[0], 1);
    cycle(4'b1011, 4'b1111, 1, 0, 0);
    check("rr_a3", dch[0], 3);
    cycle(4'b0000, 4'b1111, 1, 0, 0);
    cycle(4'b1001, 4'b1111, 1, 0, 0);
    cycle(4'b1001, 4'b1111, 1, 0, 0);
    check("rr_b0", dch[0], 0);
    cycle(4'b1001, 4'b1111, 1, 0, 0);
    check("rr_b3", dch[0], 3);
    repeat (3) cycle(4'b0000, 4'b1111, 1, 0, 0);

    // Stalled consumer, repeated ch2 rise overflows; then one ch2 event; then clear.
    cycle(4'b0001, 4'b1111, 0, 0, 0);
    cycle(4'b0001, 4'b1111, 0, 0, 0);
    cycle(4'b0101, 4'b1111, 0, 0, 0);
    repeat (3) cycle(4'b0001, 4'b1111, 0, 0, 0);
    cycle(4'b0101, 4'b1111, 0, 0, 0);
    check("stall_ovf", dov[0], 4'b0100);
    check("stall_valid", dv[0], 1);
    check("stall_ch", dch[0], 0);
    cycle(4'b0101, 4'b1111, 1, 0, 0);
    check("drain_ch", dch[0], 2);
    check("drain_rise", dr[0], 1);
    cycle(4'b0101, 4'b1111, 1, 0, 0);
    check("drain_once", dv[0], 0);
    cycle(4'b0101, 4'b1111, 1, 1, 0);
    check("ovf_clr", dov[0], 0);
    repeat (3) cycle(4'b0000, 4'b1111, 1, 0, 0);

    // Masked edge, edge under reset, and reset while an event is held.
    cycle(4'b0010, 4'b1101, 1, 0, 0);
    repeat (2) cycle(4'b0010, 4'b1111, 1, 0, 0);
    check("masked", dv[0], 0);
    cycle(4'b0011, 4'b1111, 1, 0, 1);
    repeat (2) cycle(4'b0011, 4'b1111, 1, 0, 0);
    check("rst_edge_quiet", dv[0], 0);
    cycle(4'b1011, 4'b1111, 0, 0, 0);
    cycle(4'b1011, 4'b1111, 0, 0, 0);
    check("held_ch3", dch[0], 3);
    cycle(4'b1011, 4'b1111, 0, 0, 1);
    check("rst_kills", dv[0], 0);
    cycle(4'b1011, 4'b1111, 1, 0, 0);

    // Randomised traffic.
    cur = 4'b1011;
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] e;
      cur = cur ^ N'($urandom & $urandom);
      e = ($urandom_range(0, 7) != 0) ? 4'b1111 : N'($urandom);
      cycle(cur, e, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
